// File: rtl/multicycle_ctrl_seq_pkg.sv
// multicycle_ctrl_seq_pkg: shared encodings for the multi-cycle MIPS control sequencer.
// Contents: state encoding enum, decoded opcodes, pc_src mux select encodings.
// Imported by multicycle_ctrl_seq and branch_cond.
package multicycle_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_MADDR = 3'b010,
    S_MEM   = 3'b011,
    S_WBLD  = 3'b100,
    S_BREX  = 3'b101,
    S_EXE   = 3'b110,
    S_WBALU = 3'b111
  } state_e;

  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // pc+4
  localparam logic [1:0] PC_SRC_BR  = 2'b01;  // branch target
  localparam logic [1:0] PC_SRC_RS  = 2'b10;  // rs (jr)
  localparam logic [1:0] PC_SRC_JMP = 2'b11;  // jump target

endpackage

// File: rtl/multicycle_ctrl_seq_if.sv
// multicycle_ctrl_seq_if: bundle between the sequencer and the next-state logic / datapath.
// Ports: next_state/opcode/zero/sign toward the sequencer; state, datapath enables,
// selects, halted and perf counters back out. slave = sequencer, master = datapath side.
interface multicycle_ctrl_seq_if #(
  parameter int COUNT_W = 32
);
  logic [2:0]         next_state;
  logic [5:0]         opcode;
  logic               zero;
  logic               sign;
  logic [2:0]         state;
  logic               ir_we;
  logic               pc_we;
  logic [1:0]         pc_src;
  logic               reg_we;
  logic               reg_dst_ra;
  logic               mem_rd;
  logic               mem_we;
  logic               wb_from_mem;
  logic               halted;
  logic [COUNT_W-1:0] cycle_count;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output next_state, opcode, zero, sign,
    input  state, ir_we, pc_we, pc_src, reg_we, reg_dst_ra, mem_rd, mem_we,
           wb_from_mem, halted, cycle_count, instr_count
  );

  modport slave (
    input  next_state, opcode, zero, sign,
    output state, ir_we, pc_we, pc_src, reg_we, reg_dst_ra, mem_rd, mem_we,
           wb_from_mem, halted, cycle_count, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl_seq_branch_cond.sv
// branch_cond: branch-taken decision for beq/bne/bltz, shared with the datapath PC mux checks.
// Ports: i_opcode (IR[31:26]), i_zero, i_sign (ALU flags) -> o_taken.
// Purely combinational; non-branch opcodes are never taken.
module branch_cond
  import multicycle_ctrl_seq_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_sign,
  output logic       o_taken
);

  assign o_taken = ((i_opcode == OP_BEQ)  &  i_zero) |
                   ((i_opcode == OP_BNE)  & ~i_zero) |
                   ((i_opcode == OP_BLTZ) &  i_sign);

endmodule

// File: rtl/multicycle_ctrl_seq.sv
// multicycle_ctrl_seq: state register, halt latch and per-state control decode of the multi-cycle MIPS.
// Ports: clk, rst (sync, active-high), bus (multicycle_ctrl_seq_if.slave) carrying
// next_state/opcode/flags in and state, enables, selects, halted, counters out.
// Optional perf counters under macro MULTICYCLE_CTRL_PERF_EN; otherwise counters read 0.
module multicycle_ctrl_seq
  import multicycle_ctrl_seq_pkg::*;
#(
  parameter int         COUNT_W     = 32,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_seq_if.slave  bus
);

  state_e r_state;
  logic   r_halted;

  logic       w_taken;
  logic       w_halt_dec;
  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic       w_reg_we;
  logic       w_reg_dst_ra;
  logic       w_mem_rd;
  logic       w_mem_we;
  logic       w_wb_from_mem;

  branch_cond u_branch_cond (
    .i_opcode (bus.opcode),
    .i_zero   (bus.zero),
    .i_sign   (bus.sign),
    .o_taken  (w_taken)
  );

  // Halt is recognised in ID only; the decode edge itself still counts as a live edge.
  assign w_halt_dec = !r_halted && (r_state == S_ID) && (bus.opcode == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IF;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (w_halt_dec) begin
        r_halted <= 1'b1;
        r_state  <= S_IF;
      end else begin
        r_state  <= state_e'(bus.next_state);
      end
    end
  end

  always_comb begin
    w_ir_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_src      = PC_SRC_SEQ;
    w_reg_we      = 1'b0;
    w_reg_dst_ra  = 1'b0;
    w_mem_rd      = 1'b0;
    w_mem_we      = 1'b0;
    w_wb_from_mem = 1'b0;
    // While halted the state sits at IF; gating here keeps ir_we from firing.
    if (!r_halted) begin
      case (r_state)
        S_IF: w_ir_we = 1'b1;
        S_ID: begin
          case (bus.opcode)
            OP_J: begin
              w_pc_we  = 1'b1;
              w_pc_src = PC_SRC_JMP;
            end
            OP_JR: begin
              w_pc_we  = 1'b1;
              w_pc_src = PC_SRC_RS;
            end
            OP_JAL: begin
              w_pc_we      = 1'b1;
              w_pc_src     = PC_SRC_JMP;
              w_reg_we     = 1'b1;
              w_reg_dst_ra = 1'b1;
            end
            default: ;
          endcase
        end
        S_BREX: begin
          w_pc_we  = 1'b1;
          w_pc_src = w_taken ? PC_SRC_BR : PC_SRC_SEQ;
        end
        S_MEM: begin
          if (bus.opcode == OP_SW) begin
            w_mem_we = 1'b1;
            w_pc_we  = 1'b1;
          end else if (bus.opcode == OP_LW) begin
            w_mem_rd = 1'b1;
          end
        end
        S_WBLD: begin
          w_reg_we      = 1'b1;
          w_wb_from_mem = 1'b1;
          w_pc_we       = 1'b1;
        end
        S_WBALU: begin
          w_reg_we = 1'b1;
          w_pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state       = r_state;
  assign bus.halted      = r_halted;
  assign bus.ir_we       = w_ir_we;
  assign bus.pc_we       = w_pc_we;
  assign bus.pc_src      = w_pc_src;
  assign bus.reg_we      = w_reg_we;
  assign bus.reg_dst_ra  = w_reg_dst_ra;
  assign bus.mem_rd      = w_mem_rd;
  assign bus.mem_we      = w_mem_we;
  assign bus.wb_from_mem = w_wb_from_mem;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [COUNT_W-1:0] r_cycle_count;
  logic [COUNT_W-1:0] r_instr_count;

  // Both counters freeze once halted; the halt-decode edge retires the halt itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else if (!r_halted) begin
      r_cycle_count <= r_cycle_count + COUNT_W'(1);
      if (w_pc_we || w_halt_dec) begin
        r_instr_count <= r_instr_count + COUNT_W'(1);
      end
    end
  end

  assign bus.cycle_count = r_cycle_count;
  assign bus.instr_count = r_instr_count;
`else
  assign bus.cycle_count = '0;
  assign bus.instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// tb_multicycle_ctrl_seq: self-checking bench for multicycle_ctrl_seq.
// Each cycle pushes the expected state/controls to a scoreboard, then pops and compares.
// Counter expectations come from a small cycle/retire model; zero when perf is compiled out.
module tb_multicycle_ctrl_seq;
  import multicycle_ctrl_seq_pkg::*;

  localparam int CW = 32;

  // ctrl vector: {ir_we, pc_we, pc_src[1:0], reg_we, reg_dst_ra, mem_rd, mem_we, wb_from_mem}
  localparam logic [8:0] C_NONE  = 9'b0_0_00_0_0_0_0_0;
  localparam logic [8:0] C_IF    = 9'b1_0_00_0_0_0_0_0;
  localparam logic [8:0] C_J     = 9'b0_1_11_0_0_0_0_0;
  localparam logic [8:0] C_JR    = 9'b0_1_10_0_0_0_0_0;
  localparam logic [8:0] C_JAL   = 9'b0_1_11_1_1_0_0_0;
  localparam logic [8:0] C_BT    = 9'b0_1_01_0_0_0_0_0;
  localparam logic [8:0] C_BN    = 9'b0_1_00_0_0_0_0_0;
  localparam logic [8:0] C_SW    = 9'b0_1_00_0_0_0_1_0;
  localparam logic [8:0] C_LWM   = 9'b0_0_00_0_0_1_0_0;
  localparam logic [8:0] C_WBLD  = 9'b0_1_00_1_0_0_0_1;
  localparam logic [8:0] C_WBALU = 9'b0_1_00_1_0_0_0_0;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_ALU  = 6'b000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_seq_if #(.COUNT_W(CW)) bus ();

  multicycle_ctrl_seq #(.COUNT_W(CW), .HALT_OPCODE(OP_HALT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [12:0]   sb[$];
  logic [CW-1:0] m_cyc;
  logic [CW-1:0] m_ins;
  logic          m_halted;

  task automatic step(input logic [2:0] e_state, input logic e_halted, input logic [8:0] e_ctrl,
                      input logic [2:0] ns, input logic [5:0] op, input logic z, input logic s,
                      input logic r, input logic halt_edge);
    logic [12:0]   exp_v;
    logic [12:0]   got_v;
    logic [CW-1:0] ec;
    logic [CW-1:0] ei;
    @(negedge clk);
    rst            = r;
    bus.next_state = ns;
    bus.opcode     = op;
    bus.zero       = z;
    bus.sign       = s;
    sb.push_back({e_state, e_halted, e_ctrl});
    #1;
    exp_v = sb.pop_front();
    got_v = {bus.state, bus.halted, bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_we,
             bus.reg_dst_ra, bus.mem_rd, bus.mem_we, bus.wb_from_mem};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL ctrl t=%0t op=%b got state/halt/ctrl=%b required=%b", $time, op, got_v, exp_v);
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    ec = m_cyc;
    ei = m_ins;
`else
    ec = '0;
    ei = '0;
`endif
    checks++;
    if (bus.cycle_count !== ec) begin
      failures++;
      $display("FAIL cycle_count t=%0t got=%0d required=%0d", $time, bus.cycle_count, ec);
    end
    checks++;
    if (bus.instr_count !== ei) begin
      failures++;
      $display("FAIL instr_count t=%0t got=%0d required=%0d", $time, bus.instr_count, ei);
    end
    // Advance the counter model across the coming edge.
    if (r) begin
      m_cyc    = '0;
      m_ins    = '0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      m_cyc = m_cyc + 1'b1;
      if (e_ctrl[7] || halt_edge) m_ins = m_ins + 1'b1;
      if (halt_edge) m_halted = 1'b1;
    end
  endtask

  task automatic st(input logic [2:0] e_state, input logic [8:0] e_ctrl, input logic [2:0] ns,
                    input logic [5:0] op, input logic z, input logic s);
    step(e_state, 1'b0, e_ctrl, ns, op, z, s, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.next_state = 3'b001;
    bus.opcode     = OP_SW;
    bus.zero       = 1'b0;
    bus.sign       = 1'b0;
    repeat (2) @(posedge clk);
    m_cyc    = '0;
    m_ins    = '0;
    m_halted = 1'b0;
    st(S_IF, C_IF, 3'b000, OP_ALU, 1'b0, 1'b0);
  endtask

  task automatic test_lw();
    logic [CW-1:0] ei;
    st(S_IF,    C_IF,   3'b001, OP_LW, 1'b0, 1'b0);
    st(S_ID,    C_NONE, 3'b010, OP_LW, 1'b0, 1'b0);
    st(S_MADDR, C_NONE, 3'b011, OP_LW, 1'b0, 1'b0);
    st(S_MEM,   C_LWM,  3'b100, OP_LW, 1'b0, 1'b0);
    st(S_WBLD,  C_WBLD, 3'b000, OP_LW, 1'b0, 1'b0);
    @(posedge clk);
    #1;
`ifdef MULTICYCLE_CTRL_PERF_EN
    ei = CW'(1);
`else
    ei = '0;
`endif
    checks++;
    if (bus.instr_count !== ei) begin
      failures++;
      $display("FAIL lw_retire got=%0d required=%0d", bus.instr_count, ei);
    end
  endtask

  task automatic br(input logic [5:0] op, input logic z, input logic s, input logic [8:0] c);
    st(S_IF,   C_IF,   3'b001, op, z, s);
    st(S_ID,   C_NONE, 3'b101, op, z, s);
    st(S_BREX, c,      3'b000, op, z, s);
  endtask

  task automatic test_branch();
    br(OP_BEQ,  1'b1, 1'b0, C_BT);
    br(OP_BNE,  1'b1, 1'b0, C_BN);
    br(OP_BLTZ, 1'b0, 1'b1, C_BT);
    br(OP_BEQ,  1'b0, 1'b1, C_BN);
    br(OP_BNE,  1'b0, 1'b0, C_BT);
    br(OP_BLTZ, 1'b1, 1'b0, C_BN);
  endtask

  task automatic test_jump();
    logic [5:0] ops [3] = '{OP_J, OP_JR, OP_JAL};
    logic [8:0] exps[3] = '{C_J, C_JR, C_JAL};
    for (int i = 0; i < 3; i++) begin
      st(S_IF, C_IF,    3'b001, ops[i], 1'b0, 1'b0);
      st(S_ID, exps[i], 3'b000, ops[i], 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    // sw then ALU op, back to back
    st(S_IF,    C_IF,    3'b001, OP_SW,  1'b0, 1'b0);
    st(S_ID,    C_NONE,  3'b010, OP_SW,  1'b0, 1'b0);
    st(S_MADDR, C_NONE,  3'b011, OP_SW,  1'b0, 1'b0);
    st(S_MEM,   C_SW,    3'b000, OP_SW,  1'b0, 1'b0);
    st(S_IF,    C_IF,    3'b001, OP_ALU, 1'b0, 1'b0);
    st(S_ID,    C_NONE,  3'b110, OP_ALU, 1'b0, 1'b0);
    st(S_EXE,   C_NONE,  3'b111, OP_ALU, 1'b1, 1'b1);
    st(S_WBALU, C_WBALU, 3'b000, OP_ALU, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    st(S_IF, C_IF, 3'b001, OP_HALT, 1'b0, 1'b0);
    step(S_ID, 1'b0, C_NONE, 3'b010, OP_HALT, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(S_IF, 1'b1, C_NONE, 3'b001, (i % 2 == 0) ? OP_SW : OP_J, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    // reset while halted clears the halt, then abort a sw in MEM
    step(S_IF, 1'b1, C_NONE, 3'b001, OP_SW, 1'b0, 1'b0, 1'b1, 1'b0);
    st(S_IF,    C_IF,   3'b001, OP_SW, 1'b0, 1'b0);
    st(S_ID,    C_NONE, 3'b010, OP_SW, 1'b0, 1'b0);
    st(S_MADDR, C_NONE, 3'b011, OP_SW, 1'b0, 1'b0);
    step(S_MEM, 1'b0, C_SW, 3'b000, OP_SW, 1'b0, 1'b0, 1'b1, 1'b0);
    st(S_IF,    C_IF,   3'b001, OP_SW, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_branch();
    test_jump();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
